// File: rtl/wb_dual_port_responder.sv
// Wishbone responder shared by the CPU ifetch (read-only) and memory (read/write) ports.
// One single-ported line array, round-robin arbitration, programmable wait states, byte-lane writes.
module wb_dual_port_responder #(
    parameter int DATA_W      = 128,
    parameter int ADDR_W      = 28,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2,
    localparam int SEL_W      = DATA_W / 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              i_cyc,
    input  logic              i_stb,
    input  logic [ADDR_W-1:0] i_adr,
    output logic [DATA_W-1:0] i_dat_s,
    output logic              i_ack,
    output logic              i_err,
    input  logic              d_cyc,
    input  logic              d_stb,
    input  logic              d_we,
    input  logic [SEL_W-1:0]  d_sel,
    input  logic [ADDR_W-1:0] d_adr,
    input  logic [DATA_W-1:0] d_dat_m,
    output logic [DATA_W-1:0] d_dat_s,
    output logic              d_ack,
    output logic              d_err
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_t;

    state_t            state;
    port_t             g_port;
    port_t             rr_last;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] lat_adr;
    logic              lat_we;
    logic [SEL_W-1:0]  lat_sel;
    logic [DATA_W-1:0] lat_dat;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              i_req;
    logic              d_req;
    logic              grant_d;
    logic              g_cyc;
    logic              in_range;
    logic              mem_we;
    logic [IDX_W-1:0]  idx;

    // A port still seeing its own ACK/ERR has not yet had a chance to drop stb.
    assign i_req    = i_cyc && i_stb && !(i_ack || i_err);
    assign d_req    = d_cyc && d_stb && !(d_ack || d_err);
    assign grant_d  = d_req && (!i_req || rr_last == PORT_I);
    assign g_cyc    = (g_port == PORT_D) ? d_cyc : i_cyc;
    assign in_range = lat_adr < ADDR_W'(DEPTH);
    assign idx      = lat_adr[IDX_W-1:0];
    assign mem_we   = Reset_n && state == RESP && in_range && lat_we;

    // NOTE: the line array has no reset; clearing it would turn the RAM into flops.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            for (int k = 0; k < SEL_W; k++) begin
                if (lat_sel[k]) mem[idx][k*8 +: 8] <= lat_dat[k*8 +: 8];
            end
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state   <= IDLE;
            g_port  <= PORT_I;
            rr_last <= PORT_D;
            cnt     <= '0;
            lat_adr <= '0;
            lat_we  <= 1'b0;
            lat_sel <= '0;
            lat_dat <= '0;
            i_ack   <= 1'b0;
            i_err   <= 1'b0;
            d_ack   <= 1'b0;
            d_err   <= 1'b0;
            i_dat_s <= '0;
            d_dat_s <= '0;
        end else begin
            i_ack <= 1'b0;
            i_err <= 1'b0;
            d_ack <= 1'b0;
            d_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        g_port  <= grant_d ? PORT_D : PORT_I;
                        lat_adr <= grant_d ? d_adr : i_adr;
                        lat_we  <= grant_d && d_we;
                        lat_sel <= d_sel;
                        lat_dat <= d_dat_m;
                        cnt     <= '0;
                        state   <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (!g_cyc) begin
                        state <= IDLE;
                    end else if (cnt == 4'(WAIT_CYCLES - 1)) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RESP: begin
                    if (!in_range) begin
                        if (g_port == PORT_D) d_err <= 1'b1;
                        else                  i_err <= 1'b1;
                    end else if (g_port == PORT_D) begin
                        d_ack <= 1'b1;
                        if (!lat_we) d_dat_s <= mem[idx];
                    end else begin
                        i_ack   <= 1'b1;
                        i_dat_s <= mem[idx];
                    end
                    rr_last <= g_port;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
